// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops fixed-length bursts from the async FIFO read port onto a valid/ready stream
// Optional statistics counters: define FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader #(
  parameter int DATA_LINES = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_LINES-1:0] rdata,
  output logic                  rinc,
  input  logic                  rd_en,
  output logic [DATA_LINES-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [CNT_W-1:0]      burst_count,
  output logic [CNT_W-1:0]      stall_count
`endif
);

  generate
    if (BURST_LEN < 1 || BURST_LEN > 255 || CNT_W < 1) begin : g_bad_params
      $error("fifo_burst_reader: BURST_LEN must be 1..255 and CNT_W at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [7:0]            beats_left_q, beats_left_d;
  logic [1:0]            buf_count_q, buf_count_d;
  logic [DATA_LINES-1:0] head_data_q, head_data_d;
  logic                  head_last_q, head_last_d;
  logic [DATA_LINES-1:0] tail_data_q, tail_data_d;
  logic                  tail_last_q, tail_last_d;
  logic                  pop;
  logic                  xfer;
  logic                  pop_last;

`ifdef FIFO_BURST_READER_STATS_EN
  logic [CNT_W-1:0]      burst_count_q, burst_count_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;
`endif

  always_comb begin
    pop          = (state_q == S_BURST) && !rempty && (buf_count_q < 2'd2) &&
                   (beats_left_q != 8'd0) && !rrst;
    xfer         = (buf_count_q != 2'd0) && m_ready;
    pop_last     = (beats_left_q == 8'd1);
    state_d      = state_q;
    beats_left_d = beats_left_q;
    buf_count_d  = buf_count_q;
    head_data_d  = head_data_q;
    head_last_d  = head_last_q;
    tail_data_d  = tail_data_q;
    tail_last_d  = tail_last_q;

    // Head is the presented beat; tail holds the second word while downstream stalls.
    if (pop && xfer) begin
      if (buf_count_q == 2'd1) begin
        head_data_d = rdata;
        head_last_d = pop_last;
      end else begin
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
        tail_data_d = rdata;
        tail_last_d = pop_last;
      end
    end else if (pop) begin
      if (buf_count_q == 2'd0) begin
        head_data_d = rdata;
        head_last_d = pop_last;
      end else begin
        tail_data_d = rdata;
        tail_last_d = pop_last;
      end
      buf_count_d = buf_count_q + 2'd1;
    end else if (xfer) begin
      head_data_d = tail_data_q;
      head_last_d = tail_last_q;
      buf_count_d = buf_count_q - 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (rd_en && !rempty) begin
          state_d      = S_BURST;
          beats_left_d = 8'(BURST_LEN);
        end
      end
      S_BURST: begin
        if (pop) begin
          beats_left_d = beats_left_q - 8'd1;
          if (pop_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (buf_count_d == 2'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef FIFO_BURST_READER_STATS_EN
    burst_count_d = burst_count_q;
    stall_count_d = stall_count_q;
    if (xfer && head_last_q && !(&burst_count_q)) burst_count_d = burst_count_q + 1'b1;
    if ((state_q == S_BURST) && rempty && !(&stall_count_q)) stall_count_d = stall_count_q + 1'b1;
`endif
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q      <= S_IDLE;
      beats_left_q <= 8'd0;
      buf_count_q  <= 2'd0;
      head_data_q  <= '0;
      head_last_q  <= 1'b0;
      tail_data_q  <= '0;
      tail_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      buf_count_q  <= buf_count_d;
      head_data_q  <= head_data_d;
      head_last_q  <= head_last_d;
      tail_data_q  <= tail_data_d;
      tail_last_q  <= tail_last_d;
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      burst_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      burst_count_q <= burst_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign burst_count = burst_count_q;
  assign stall_count = stall_count_q;
`endif

  assign rinc    = pop;
  assign m_valid = (buf_count_q != 2'd0);
  assign m_data  = head_data_q;
  assign m_last  = head_last_q && m_valid;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader (BURST_LEN 4 and 1)
module tb_fifo_burst_reader;

  logic       rclk;
  logic       rrst;

  logic       rempty0, rinc0, rd_en0, m_valid0, m_ready0, m_last0, busy0;
  logic [7:0] rdata0, m_data0;
  logic       rempty1, rinc1, rd_en1, m_valid1, m_ready1, m_last1, busy1;
  logic [7:0] rdata1, m_data1;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0] burst_count0, stall_count0, burst_count1, stall_count1;
`endif

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [8:0] cap0[$];
  logic [8:0] cap1[$];

  int checks = 0;
  int errors = 0;

  fifo_burst_reader #(.DATA_LINES(8), .BURST_LEN(4), .CNT_W(16)) dut0 (
    .rclk(rclk), .rrst(rrst), .rempty(rempty0), .rdata(rdata0), .rinc(rinc0),
    .rd_en(rd_en0), .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0),
    .m_last(m_last0), .busy(busy0)
`ifdef FIFO_BURST_READER_STATS_EN
    , .burst_count(burst_count0), .stall_count(stall_count0)
`endif
  );

  fifo_burst_reader #(.DATA_LINES(8), .BURST_LEN(1), .CNT_W(16)) dut1 (
    .rclk(rclk), .rrst(rrst), .rempty(rempty1), .rdata(rdata1), .rinc(rinc1),
    .rd_en(rd_en1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_last(m_last1), .busy(busy1)
`ifdef FIFO_BURST_READER_STATS_EN
    , .burst_count(burst_count1), .stall_count(stall_count1)
`endif
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic refresh0();
    rempty0 = (q0.size() == 0);
    rdata0  = (q0.size() != 0) ? q0[0] : 8'h00;
  endtask

  task automatic refresh1();
    rempty1 = (q1.size() == 0);
    rdata1  = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  // Show-ahead FIFO models: pop on the edge, present the new head shortly after it.
  always @(posedge rclk) begin
    if (rinc0 && q0.size() != 0) void'(q0.pop_front());
    if (rinc1 && q1.size() != 0) void'(q1.pop_front());
    if (m_valid0 && m_ready0) cap0.push_back({m_last0, m_data0});
    if (m_valid1 && m_ready1) cap1.push_back({m_last1, m_data1});
    #1;
    refresh0();
    refresh1();
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cap0(input string tag, input logic [8:0] e0, input logic [8:0] e1,
                            input logic [8:0] e2, input logic [8:0] e3);
    logic [8:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({tag, "_count"}, cap0.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < cap0.size()) check($sformatf("%s_beat%0d", tag, i), {23'd0, cap0[i]}, {23'd0, e[i]});
  endtask

  // Expected per-cycle values after each of the six edges following reset release
  logic       exp_rinc  [6] = '{1, 1, 1, 1, 0, 0};
  logic       exp_valid [6] = '{0, 1, 1, 1, 1, 0};
  logic [7:0] exp_data  [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
  logic       exp_last  [6] = '{0, 0, 0, 0, 1, 0};
  logic       exp_busy  [6] = '{1, 1, 1, 1, 1, 0};
  logic       exp_busy1 [10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
  logic       exp_rinc1 [10] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 0};

  initial begin
    rrst = 1'b1;
    rd_en0 = 1'b1; m_ready0 = 1'b1;
    rd_en1 = 1'b0; m_ready1 = 1'b1;
    q0 = '{8'h11, 8'h22, 8'h33, 8'h44};
    refresh0();
    refresh1();

    // Reset held three cycles with data waiting and rd_en high
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      check($sformatf("rst_rinc%0d", i), rinc0, 0);
      check($sformatf("rst_valid%0d", i), m_valid0, 0);
      check($sformatf("rst_busy%0d", i), busy0, 0);
    end
    check("rst_data", m_data0, 8'h00);
    check("rst_last", m_last0, 0);
    rrst = 1'b0;
    #1;
    check("rst_first_cycle_rinc", rinc0, 0);

    // Basic burst of four
    for (int i = 0; i < 6; i++) begin
      @(negedge rclk);
      check($sformatf("basic_rinc%0d", i), rinc0, exp_rinc[i]);
      check($sformatf("basic_valid%0d", i), m_valid0, exp_valid[i]);
      if (exp_valid[i]) check($sformatf("basic_data%0d", i), m_data0, exp_data[i]);
      check($sformatf("basic_last%0d", i), m_last0, exp_last[i]);
      check($sformatf("basic_busy%0d", i), busy0, exp_busy[i]);
    end
    check_cap0("basic", 9'h011, 9'h022, 9'h033, 9'h144);

    // Backpressure: downstream stalls five cycles from first valid
    rd_en0 = 1'b0;
    @(negedge rclk);
    cap0.delete();
    m_ready0 = 1'b0;
    q0 = '{8'h11, 8'h22, 8'h33, 8'h44};
    refresh0();
    rd_en0 = 1'b1;
    @(negedge rclk);
    @(negedge rclk);
    check("bp_first_valid", m_valid0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      check($sformatf("bp_rinc%0d", i), rinc0, 0);
      check($sformatf("bp_valid%0d", i), m_valid0, 1);
      check($sformatf("bp_data%0d", i), m_data0, 8'h11);
    end
    check("bp_fifo_left", q0.size(), 2);
    m_ready0 = 1'b1;
    rd_en0 = 1'b0;
    repeat (8) @(negedge rclk);
    check_cap0("bp", 9'h011, 9'h022, 9'h033, 9'h144);
    check("bp_busy_end", busy0, 0);

    // Underflow mid-burst: two words, six empty cycles, two more
    cap0.delete();
    q0 = '{8'h55, 8'h66};
    refresh0();
    rd_en0 = 1'b1;
    repeat (3) @(negedge rclk);
    rd_en0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("uf_rinc%0d", i), rinc0, 0);
      check($sformatf("uf_busy%0d", i), busy0, 1);
      @(negedge rclk);
    end
    q0.push_back(8'h77);
    q0.push_back(8'h88);
    refresh0();
    repeat (6) @(negedge rclk);
    check_cap0("uf", 9'h055, 9'h066, 9'h077, 9'h188);
    check("uf_busy_end", busy0, 0);
`ifdef FIFO_BURST_READER_STATS_EN
    check("uf_stall_count", stall_count0, 16'd6);
    check("uf_burst_count", burst_count0, 16'd3);
`endif

    // Reset after two of four pops
    m_ready0 = 1'b0;
    q0 = '{8'h91, 8'h92, 8'h93, 8'h94};
    refresh0();
    rd_en0 = 1'b1;
    repeat (3) @(negedge rclk);
    check("mr_fifo_left", q0.size(), 2);
    rrst = 1'b1;
    @(negedge rclk);
    check("mr_valid", m_valid0, 0);
    check("mr_busy", busy0, 0);
    check("mr_rinc", rinc0, 0);
    rrst = 1'b0;
    cap0.delete();
    q0.push_back(8'h95);
    q0.push_back(8'h96);
    refresh0();
    m_ready0 = 1'b1;
    repeat (2) @(negedge rclk);
    rd_en0 = 1'b0;
    repeat (10) @(negedge rclk);
    check_cap0("mr", 9'h093, 9'h094, 9'h095, 9'h196);
    check("mr_busy_end", busy0, 0);

    // BURST_LEN=1: three single-beat bursts, one IDLE cycle between them
    q1 = '{8'hA1, 8'hB2, 8'hC3};
    refresh1();
    rd_en1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      check($sformatf("bl1_busy%0d", i), busy1, exp_busy1[i]);
      check($sformatf("bl1_rinc%0d", i), rinc1, exp_rinc1[i]);
      if (m_valid1) check($sformatf("bl1_last%0d", i), m_last1, 1);
    end
    rd_en1 = 1'b0;
    check("bl1_count", cap1.size(), 3);
    if (cap1.size() > 0) check("bl1_beat0", {23'd0, cap1[0]}, 32'h1A1);
    if (cap1.size() > 1) check("bl1_beat1", {23'd0, cap1[1]}, 32'h1B2);
    if (cap1.size() > 2) check("bl1_beat2", {23'd0, cap1[2]}, 32'h1C3);
`ifdef FIFO_BURST_READER_STATS_EN
    check("bl1_burst_count", burst_count1, 16'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the async FIFO. Lives in the read clock domain.
- Pops words from the FIFO read port (rinc/rdata/rempty) and groups them into fixed-length bursts.
- Presents the bursts downstream on a valid/ready stream with a last-beat marker.
- A 2-entry skid buffer decouples FIFO pops from downstream backpressure, so no word is lost or duplicated.

Parameters:
- DATA_LINES, 8, width of FIFO words and of m_data.
- BURST_LEN, 4, words per burst; legal range 1..255.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- rclk  input  1  read-domain clock; all logic on its rising edge.
- rrst  input  1  reset, synchronous, active-high.
- rempty  input  1  FIFO empty flag; when low, rdata holds the head word.
- rdata  input  DATA_LINES  FIFO head word (show-ahead, combinational from raddr).
- rinc  output  1  FIFO pop strobe; one word consumed per cycle it is high.
- rd_en  input  1  burst enable; sampled only in IDLE.
- m_data  output  DATA_LINES  downstream data.
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accept.
- m_last  output  1  high with the final beat of each burst.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rrst=1 at a rclk edge):
  - state goes to IDLE; skid buffer and beat counter are cleared.
  - m_valid=0, m_last=0, m_data=0, busy=0.
  - rinc is 0 while rrst is high.
  - Reset mid-burst discards buffered words. Those words were already popped from the FIFO and are lost by design.
- rinc is combinational: rinc = (state==BURST) && !rempty && (buf_count<2) && (beats_left>0).
  - rinc is never high while rempty=1.
- Popped word: rdata is written into the skid buffer at the same edge, tagged last when beats_left==1.
- Latency: a word popped at edge N is visible on m_data/m_valid after edge N, i.e. 1 cycle, when the buffer was empty.
- Output transfer occurs when m_valid && m_ready; the buffer head advances.
  - Pop and transfer in the same cycle keep buf_count unchanged.
  - FIFO order is preserved.
- m_data, m_valid and m_last are driven from the buffer head register. They stay stable while m_valid && !m_ready.
- States:
  - IDLE: if rd_en && !rempty, go to BURST and set beats_left=BURST_LEN. rd_en with rempty=1 stays in IDLE.
  - BURST: pop under the rinc rule and decrement beats_left per pop.
    - If the FIFO empties mid-burst, stay in BURST and wait. No short bursts are generated.
    - When beats_left reaches 0 (after the last pop), go to DRAIN.
    - Deasserting rd_en mid-burst has no effect; the burst completes.
  - DRAIN: no pops. Go to IDLE when the buffer is empty, i.e. the last beat has transferred.
    - From IDLE, the next burst may start the following cycle.
- busy=1 in BURST and DRAIN.
- Width rules:
  - beats_left is 8 bits.
  - buf_count takes values 0..2.
- Simultaneous events:
  - A pop of the last beat together with a transfer of the previous beat is legal and handled.
  - With BURST_LEN=1, every beat carries m_last=1.
- Throughput: 1 word/cycle sustained with m_ready=1 and the FIFO non-empty, except for one IDLE cycle between bursts.

Optional Feature:
- Macro: FIFO_BURST_READER_STATS_EN.
- Defined:
  - Adds outputs burst_count [CNT_W-1:0] (increments on each m_last transfer) and stall_count [CNT_W-1:0] (increments each BURST cycle with rempty=1).
  - Both counters saturate at all-ones and reset to 0 on rrst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rrst 3 cycles with rempty=0 and rd_en=1 -> rinc=0, m_valid=0, busy=0 throughout. First rinc occurs no earlier than the 2nd cycle after rrst falls.
- Basic burst, BURST_LEN=4: FIFO holds 8'h11,22,33,44; rd_en=1; m_ready=1 -> rinc high 4 consecutive cycles. m_data 11,22,33,44 on consecutive cycles; m_last only with 44; busy returns to 0.
- Backpressure: 4 words queued; m_ready=0 for 5 cycles after first valid -> rinc stops after 2 pops (buffer full). m_data holds 8'h11 stable. When m_ready=1 is released, all 4 words are delivered in order with no duplicates.
- Underflow mid-burst: 2 words, then rempty=1 for 6 cycles, then 2 more words -> state stays BURST and rinc=0 while empty. Exactly one m_last, on the 4th word. With FIFO_BURST_READER_STATS_EN, stall_count=6.
- Reset mid-burst: rrst pulsed after 2 of 4 pops -> next cycle m_valid=0 and busy=0. A new burst starts from a fresh count of 4.
- BURST_LEN=1 with 3 words and m_ready=1 -> 3 single-beat bursts, each with m_last=1, separated by one IDLE cycle. With stats enabled, burst_count=3.
